// File: rtl/pat_detect_param.sv
// pat_detect_param: maskable serial pattern detector, optional saturating hit counter (PAT_DETECT_COUNT_EN)
module pat_detect_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap,
    output logic             data_detected,
`ifdef PAT_DETECT_COUNT_EN
    output logic [CNT_W-1:0] hit_count,
`endif
    output logic             fill_done
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    // only the youngest PAT_W-1 bits are kept: the oldest bit is shifted out before it could ever be compared
    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill, fill_nxt;
    logic [PAT_W-1:0] pat_q, mask_q, cand;
    logic             ovl_q, match;

    // candidate history with the incoming bit and the masked compare against it
    always_comb begin
        cand     = {hist, in_data};
        fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
        match    = (fill_nxt == FULL) && (((cand ^ pat_q) & mask_q) == '0);
    end

    // config latch, history shift, fill tracking and the detect pulse
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hist          <= '0;
            fill          <= '0;
            pat_q         <= '0;
            mask_q        <= '1;
            ovl_q         <= 1'b1;
            data_detected <= 1'b0;
        end else if (cfg_load) begin
            hist          <= '0;
            fill          <= '0;
            pat_q         <= pattern;
            mask_q        <= mask;
            ovl_q         <= overlap;
            data_detected <= 1'b0;
        end else if (in_valid) begin
            hist          <= cand[PAT_W-2:0];
            fill          <= (match && !ovl_q) ? '0 : fill_nxt;
            data_detected <= match;
        end else begin
            data_detected <= 1'b0;
        end
    end

    assign fill_done = (fill == FULL);

`ifdef PAT_DETECT_COUNT_EN
    // saturating count of matches since reset or the last config load
    always_ff @(posedge clk or negedge res) begin
        if (!res)
            hit_count <= '0;
        else if (cfg_load)
            hit_count <= '0;
        else if (in_valid && match && hit_count != '1)
            hit_count <= hit_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pat_detect_param.sv
// tb_pat_detect_param: directed vectors against three pat_detect_param instances
module tb_pat_detect_param;
    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       cfg_load = 1'b0;
    logic       overlap = 1'b1;
    logic [2:0] pat3 = '0, mask3 = '1, pat2 = '0, mask2 = '1;
    logic [7:0] pat8 = '0, mask8 = '1;
    logic       det3, det8, det2, fd3, fd8, fd2;
`ifdef PAT_DETECT_COUNT_EN
    logic [15:0] hc3, hc8;
    logic [1:0]  hc2;
`endif
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pat_detect_param #(.PAT_W(3), .CNT_W(16)) u3 (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .cfg_load(cfg_load),
        .pattern(pat3), .mask(mask3), .overlap(overlap), .data_detected(det3),
`ifdef PAT_DETECT_COUNT_EN
        .hit_count(hc3),
`endif
        .fill_done(fd3));

    pat_detect_param #(.PAT_W(8), .CNT_W(16)) u8 (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .cfg_load(cfg_load),
        .pattern(pat8), .mask(mask8), .overlap(overlap), .data_detected(det8),
`ifdef PAT_DETECT_COUNT_EN
        .hit_count(hc8),
`endif
        .fill_done(fd8));

    pat_detect_param #(.PAT_W(3), .CNT_W(2)) u2 (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .cfg_load(cfg_load),
        .pattern(pat2), .mask(mask2), .overlap(overlap), .data_detected(det2),
`ifdef PAT_DETECT_COUNT_EN
        .hit_count(hc2),
`endif
        .fill_done(fd2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick(input logic v, input logic d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg(input logic ovl, input logic v);
        overlap  = ovl;
        cfg_load = 1'b1;
        tick(v, 1'b1);
        cfg_load = 1'b0;
    endtask

    initial begin
        logic [4:0] s5;
        logic [7:0] s8;
        logic [3:0] gaps;
        #2;
        chk("rst_det", {31'd0, det3}, 0);
        chk("rst_fd", {31'd0, fd3}, 0);
        #10 res = 1'b1;
        @(posedge clk);
        #1;
        // 101 overlapping: pulses on bits 3 and 5
        pat3 = 3'b101; mask3 = 3'b111;
        cfg(1'b1, 1'b0);
        s5 = 5'b10101;
        for (int i = 4; i >= 0; i--) begin
            tick(1'b1, s5[i]);
            chk($sformatf("ovl_det%0d", 5 - i), {31'd0, det3}, (i == 2 || i == 0) ? 1 : 0);
        end
        chk("ovl_fd", {31'd0, fd3}, 1);
`ifdef PAT_DETECT_COUNT_EN
        chk("ovl_hc", {16'd0, hc3}, 2);
`endif
        // 101 non-overlapping: only bit 3, fill restarts after the match
        cfg(1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            tick(1'b1, s5[i]);
            chk($sformatf("novl_det%0d", 5 - i), {31'd0, det3}, (i == 2) ? 1 : 0);
            chk($sformatf("novl_fd%0d", 5 - i), {31'd0, fd3}, 0);
        end
        tick(1'b1, 1'b0);
        chk("novl_det6", {31'd0, det3}, 0);
        chk("novl_fd6", {31'd0, fd3}, 1);
`ifdef PAT_DETECT_COUNT_EN
        chk("novl_hc", {16'd0, hc3}, 1);
`endif
        // PAT_W=8 masked A5/F0 with valid gaps; pattern input changed after load must be ignored
        pat8 = 8'hA5; mask8 = 8'hF0;
        cfg(1'b1, 1'b0);
        pat8 = 8'h00;
        s8 = 8'b1010_1101;
        gaps = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, s8[i]);
            chk($sformatf("m8_det%0d", 8 - i), {31'd0, det8}, (i == 0) ? 1 : 0);
            gaps = 4'(1 + (i % 3));
            for (int g = 0; g < int'(gaps); g++) begin
                tick(1'b0, 1'b1);
                chk("m8_gap", {31'd0, det8}, 0);
            end
        end
        chk("m8_fd", {31'd0, fd8}, 1);
        tick(1'b1, 1'b0);
        chk("m8_det9", {31'd0, det8}, 0);
        // async reset mid-cycle with a pulse outstanding, then reset config (000, all-ones mask)
        pat3 = 3'b101; mask3 = 3'b111;
        cfg(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("ar_pre", {31'd0, det3}, 1);
        #3 res = 1'b0;
        #1;
        chk("ar_det", {31'd0, det3}, 0);
        chk("ar_fd", {31'd0, fd3}, 0);
`ifdef PAT_DETECT_COUNT_EN
        chk("ar_hc", {16'd0, hc3}, 0);
`endif
        #3 res = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 3; i++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("ar_post%0d", i), {31'd0, det3}, (i == 3) ? 1 : 0);
        end
        // cfg_load with in_valid: bit discarded, three fresh bits needed
        cfg(1'b1, 1'b1);
        chk("cv_fd", {31'd0, fd3}, 0);
`ifdef PAT_DETECT_COUNT_EN
        chk("cv_hc", {16'd0, hc3}, 0);
`endif
        s5 = 5'b00101;
        for (int i = 3; i >= 0; i--) begin
            tick(1'b1, s5[i]);
            chk($sformatf("cv_det%0d", 4 - i), {31'd0, det3}, (i == 0) ? 1 : 0);
        end
        // zero mask, non-overlap: one match every 3 valid bits
        mask3 = 3'b000;
        cfg(1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, i[0]);
            chk($sformatf("m0_det%0d", i), {31'd0, det3}, (i % 3 == 0) ? 1 : 0);
        end
        // all ones, CNT_W=2: six pulses, counter saturates at 3
        pat2 = 3'b111; mask2 = 3'b111;
        cfg(1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b1);
            chk($sformatf("sat_det%0d", i), {31'd0, det2}, (i >= 3) ? 1 : 0);
`ifdef PAT_DETECT_COUNT_EN
            chk($sformatf("sat_hc%0d", i), {30'd0, hc2}, (i < 3) ? 0 : (i > 5) ? 3 : i - 2);
`endif
        end
        tick(1'b0, 1'b1);
        chk("sat_idle", {31'd0, det2}, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
